// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream FIFO buffer.
// STREAM_FIFO_WORD_T(W) builds the packed {valid, payload} word for a given payload width.
`ifndef STREAM_FIFO_WORD_T
`define STREAM_FIFO_WORD_T(W) struct packed { logic valid; logic [(W)-1:0] payload; }
`endif

package stream_fifo_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 8;

    // Pointers carry one extra MSB so full and empty can be told apart.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // The valid flag sits directly above the payload.
    function automatic int unsigned valid_idx(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for the stream FIFO: synchronous write, asynchronous read, no reset.
module stream_fifo_mem
#(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
)
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]    rdata
);

    logic [FIFO_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_buf.sv
// Elastic FWFT buffer between a no-backpressure {valid, payload} stage and a ready-handshake consumer.
// Define STREAM_FIFO_OVF_EN to build the sticky overflow flag and its ovf/ovf_clr ports.
module stream_fifo_buf
    import stream_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FIFO_WIDTH:0]       data_i,
    input  logic                      ready_i,
    output logic [FIFO_WIDTH:0]       data_o,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH)-1:0]   count
`ifdef STREAM_FIFO_OVF_EN
    ,
    input  logic                      ovf_clr,
    output logic                      ovf
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PW        = ptr_w(DEPTH);
    localparam int unsigned VALID_BIT = valid_idx(FIFO_WIDTH);

    typedef `STREAM_FIFO_WORD_T(FIFO_WIDTH) word_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo_buf: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] head;
    word_t                 out_word;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push  = data_i[VALID_BIT];
    assign pop   = ~empty & ready_i;
    // A push into a full buffer lands only when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    stream_fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_i[FIFO_WIDTH-1:0]),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_comb begin
        out_word.valid   = ~empty;
        out_word.payload = empty ? '0 : head;
    end

    assign data_o = out_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STREAM_FIFO_OVF_EN
    logic drop;

    assign drop = push & full & ~pop;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule
